// File: rtl/ps2_scancode_rx.sv
// PS/2 device-to-host receiver: sync + glitch filter, 11-bit frame decode, scan-code FIFO.
// Optional prefix decoding (E0/F0 folded into entry flags) enabled by PS2_PREFIX_DECODE_EN.
module ps2_scancode_rx #(
  parameter int FILT_LEN = 4,
  parameter int TIMEOUT  = 20000,
  parameter int FIFO_AW  = 2
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  output logic [7:0] code,
  output logic       valid,
  output logic       err,
  output logic       overflow,
  output logic       released,
  output logic       extended
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int FCW   = $clog2(FILT_LEN + 1);
  localparam int TCW   = $clog2(TIMEOUT + 1);
`ifdef PS2_PREFIX_DECODE_EN
  localparam int EW = 10;
`else
  localparam int EW = 8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  logic [1:0]         clk_s_q, dat_s_q;
  logic               filt_q, filt_d;
  logic [FCW-1:0]     fcnt_q, fcnt_d;
  logic               bit_evt, bit_val;

  state_e             state_q, state_d;
  logic [2:0]         bcnt_q, bcnt_d;
  logic [7:0]         sr_q, sr_d;
  logic               par_q, par_d;
  logic [TCW-1:0]     tcnt_q, tcnt_d;
  logic               err_q, err_d;
  logic               push_q, push_d;
  logic [EW-1:0]      entry_q, entry_d;
`ifdef PS2_PREFIX_DECODE_EN
  logic               ext_q, ext_d, rel_q, rel_d;
`endif

  logic [EW-1:0]      mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               rd_en, wr_en, full;
  logic [EW-1:0]      head;

  // Filtered clock flips only after FILT_LEN consecutive samples disagree with it.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    fcnt_d = '0;
    filt_d = filt_q;
    if (clk_s_q[1] != filt_q) begin
      if (fcnt_q == FCW'(FILT_LEN - 1)) filt_d = clk_s_q[1];
      else                              fcnt_d = fcnt_q + FCW'(1);
    end
  end

  assign bit_evt = filt_q & ~filt_d;
  assign bit_val = dat_s_q[1];

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    sr_d    = sr_q;
    par_d   = par_q;
    tcnt_d  = tcnt_q + TCW'(1);
    err_d   = 1'b0;
    push_d  = 1'b0;
    entry_d = entry_q;
`ifdef PS2_PREFIX_DECODE_EN
    ext_d   = ext_q;
    rel_d   = rel_q;
`endif
    case (state_q)
      S_IDLE: begin
        tcnt_d = '0;
        if (bit_evt) begin
          if (!bit_val) begin
            state_d = S_DATA;
            bcnt_d  = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_DATA: if (bit_evt) begin
        sr_d   = {bit_val, sr_q[7:1]};
        bcnt_d = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = S_PARITY;
      end
      S_PARITY: if (bit_evt) begin
        par_d   = bit_val;
        state_d = S_STOP;
      end
      S_STOP: if (bit_evt) begin
        state_d = S_IDLE;
        if (bit_val && (^{sr_q, par_q})) begin
`ifdef PS2_PREFIX_DECODE_EN
          if (sr_q == 8'hE0)      ext_d = 1'b1;
          else if (sr_q == 8'hF0) rel_d = 1'b1;
          else begin
            push_d  = 1'b1;
            entry_d = {ext_q, rel_q, sr_q};
            ext_d   = 1'b0;
            rel_d   = 1'b0;
          end
`else
          push_d  = 1'b1;
          entry_d = sr_q;
`endif
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Mid-frame watchdog: a stalled device abandons the partial byte.
    if (state_q != S_IDLE) begin
      if (bit_evt) tcnt_d = '0;
      else if (tcnt_q == TCW'(TIMEOUT - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end
    end
`ifdef PS2_PREFIX_DECODE_EN
    if (err_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end
`endif
  end

  // A pop frees a slot in the same cycle, so push+rd on a full FIFO is accepted.
  always_comb begin
    rd_en = rd & valid;
    full  = (cnt_q == (FIFO_AW + 1)'(DEPTH));
    wr_en = push_q & (~full | rd_en);
    ovf_d = push_q & full & ~rd_en;
    cnt_d = cnt_q;
    if (wr_en && !rd_en)      cnt_d = cnt_q + (FIFO_AW + 1)'(1);
    else if (!wr_en && rd_en) cnt_d = cnt_q - (FIFO_AW + 1)'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s_q  <= 2'b11;
      dat_s_q  <= 2'b11;
      filt_q   <= 1'b1;
      fcnt_q   <= '0;
      state_q  <= S_IDLE;
      bcnt_q   <= '0;
      sr_q     <= '0;
      par_q    <= 1'b0;
      tcnt_q   <= '0;
      err_q    <= 1'b0;
      push_q   <= 1'b0;
      entry_q  <= '0;
`ifdef PS2_PREFIX_DECODE_EN
      ext_q    <= 1'b0;
      rel_q    <= 1'b0;
`endif
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      // NOTE: the tiny FIFO array is reset so the head reads 00 out of reset.
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      clk_s_q  <= {clk_s_q[0], ps2_clk};
      dat_s_q  <= {dat_s_q[0], ps2_dat};
      filt_q   <= filt_d;
      fcnt_q   <= fcnt_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      sr_q     <= sr_d;
      par_q    <= par_d;
      tcnt_q   <= tcnt_d;
      err_q    <= err_d;
      push_q   <= push_d;
      entry_q  <= entry_d;
`ifdef PS2_PREFIX_DECODE_EN
      ext_q    <= ext_d;
      rel_q    <= rel_d;
`endif
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      if (wr_en) begin
        mem_q[wr_ptr_q] <= entry_q;
        wr_ptr_q        <= wr_ptr_q + FIFO_AW'(1);
      end
      if (rd_en) rd_ptr_q <= rd_ptr_q + FIFO_AW'(1);
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign code     = head[7:0];
  assign valid    = (cnt_q != '0);
  assign err      = err_q;
  assign overflow = ovf_q;
`ifdef PS2_PREFIX_DECODE_EN
  assign extended = head[9];
  assign released = head[8];
`else
  assign extended = 1'b0;
  assign released = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Scoreboard bench for ps2_scancode_rx: frames are modelled into an expected queue
// and compared against the FIFO head as it is drained.
module tb_ps2_scancode_rx;

  localparam int FILT_LEN = 4;
  localparam int TIMEOUT  = 1000;
  localparam int FIFO_AW  = 2;
  localparam int DEPTH    = 4;
  localparam int HALF     = 10;

  logic       clk, reset_n, ps2_clk, ps2_dat, rd;
  logic [7:0] code;
  logic       valid, err, overflow, released, extended;

  ps2_scancode_rx #(.FILT_LEN(FILT_LEN), .TIMEOUT(TIMEOUT), .FIFO_AW(FIFO_AW)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd(rd),
    .code(code), .valid(valid), .err(err), .overflow(overflow),
    .released(released), .extended(extended)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int err_cnt = 0, ovf_cnt = 0, long_pulse = 0, exp_ovf = 0;
  logic err_prev = 1'b0, ovf_prev = 1'b0;
  logic [9:0] exp_q [$];
  bit m_ext = 1'b0, m_rel = 1'b0;

  always @(negedge clk) begin
    if (err) err_cnt++;
    if (overflow) ovf_cnt++;
    if ((err && err_prev) || (overflow && ovf_prev)) long_pulse++;
    err_prev = err;
    ovf_prev = overflow;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input bit b);
    ps2_dat = b;
    wait_clk(HALF);
    ps2_clk = 1'b0;
    wait_clk(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic enqueue(input logic [9:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else exp_ovf++;
  endtask

  task automatic model_good(input logic [7:0] d);
`ifdef PS2_PREFIX_DECODE_EN
    if (d == 8'hE0) m_ext = 1'b1;
    else if (d == 8'hF0) m_rel = 1'b1;
    else begin
      enqueue({m_ext, m_rel, d});
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
`else
    enqueue({2'b00, d});
`endif
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_par);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    send_bit(bad_par ? ^d : ~^d);
    send_bit(1'b1);
    ps2_dat = 1'b1;
    wait_clk(2 * HALF);
    if (bad_par) begin
      m_ext = 1'b0;
      m_rel = 1'b0;
    end else begin
      model_good(d);
    end
  endtask

  task automatic drain(input string tag);
    logic [9:0] e;
    for (int i = 0; i < DEPTH + 2; i++) begin
      @(negedge clk);
      if (!valid) break;
      if (exp_q.size() == 0) check({tag, "_unexpected"}, 32'(code), 32'hFFFF);
      else begin
        e = exp_q.pop_front();
        check({tag, "_code"}, 32'(code), 32'(e[7:0]));
        check({tag, "_flags"}, 32'({extended, released}), 32'(e[9:8]));
      end
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    check({tag, "_valid_end"}, 32'(valid), 32'd0);
    check({tag, "_sb_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int e0, o0, eo0;
    reset_n = 1'b0; ps2_clk = 1'b1; ps2_dat = 1'b1; rd = 1'b0;
    wait_clk(3);
    check("rst_code", 32'(code), 32'h00);
    check("rst_outs", 32'({valid, err, overflow, released, extended}), 32'd0);
    reset_n = 1'b1;
    wait_clk(5);
    check("post_rst_valid", 32'(valid), 32'd0);

    // 1: good frame, pop empties FIFO
    e0 = err_cnt;
    send_frame(8'h1C, 1'b0);
    check("t1_err", 32'(err_cnt - e0), 32'd0);
    drain("t1");

    // 2: bad parity
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1);
    check("t2_err", 32'(err_cnt - e0), 32'd1);
    check("t2_valid", 32'(valid), 32'd0);

    // 3: clock glitch one sample short of the filter length
    e0 = err_cnt;
    ps2_clk = 1'b0;
    wait_clk(FILT_LEN - 1);
    ps2_clk = 1'b1;
    wait_clk(20);
    send_frame(8'h29, 1'b0);
    check("t3_err", 32'(err_cnt - e0), 32'd0);
    drain("t3");

    // 4: overflow on fifth byte; rd held low throughout
    o0 = ovf_cnt; eo0 = exp_ovf;
    send_frame(8'h16, 1'b0);
    send_frame(8'h1E, 1'b0);
    send_frame(8'h26, 1'b0);
    send_frame(8'h25, 1'b0);
    check("t4_no_ovf_yet", 32'(ovf_cnt - o0), 32'd0);
    send_frame(8'h2E, 1'b0);
    check("t4_ovf", 32'(ovf_cnt - o0), 32'd1);
    check("t4_model_ovf", 32'(exp_ovf - eo0), 32'd1);
    drain("t4");

    // 5: stalled frame times out, next frame is clean
    e0 = err_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'(i));
    wait_clk(TIMEOUT + 50);
    check("t5_err", 32'(err_cnt - e0), 32'd1);
    check("t5_valid", 32'(valid), 32'd0);
    e0 = err_cnt;
    send_frame(8'h5A, 1'b0);
    check("t5b_err", 32'(err_cnt - e0), 32'd0);
    drain("t5");

    // 6: prefix bytes
    e0 = err_cnt;
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h74, 1'b0);
    check("t6_err", 32'(err_cnt - e0), 32'd0);
    drain("t6");

    // E1 is an ordinary byte in both builds
    send_frame(8'hE1, 1'b0);
    drain("t7");

    check("pulse_width", 32'(long_pulse), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
